if_fetch: RTL and testbench

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/if_fetch_pkg.sv | 15 +
 rtl/if_fetch.sv | 114 +++++++++++
 tb/tb_if_fetch.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_DRAIN = 2'd2,
    S_HOLD  = 2'd3
  } state_e;

  localparam int PC_INCR   = 4;
  localparam int STALL_BIT = 0;
  localparam int FLUSH_BIT = 1;

endpackage

// File: rtl/if_fetch.sv
// Instruction fetch: drives Wishbone classic reads at the PC and hands
// acknowledged words to the IF/ID register, honouring stall and flush.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] PC_ADDR    = 32'h8000_0000,
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            pc_stall_and_flush,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  output logic                  im_o,
  output logic                  if_valid_o,
  output logic [ADDR_WIDTH-1:0] if_pc_o,
  output logic [DATA_WIDTH-1:0] if_instr_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [3:0]            wb_sel_o,
  output logic                  wb_we_o,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  input  logic                  wb_ack_i
);

  localparam logic [ADDR_WIDTH-1:0] RST_PC = ADDR_WIDTH'(PC_ADDR);
  localparam logic [ADDR_WIDTH-1:0] INCR   = ADDR_WIDTH'(PC_INCR);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] pc_q, req_adr_q;
  logic [DATA_WIDTH-1:0] hold_instr_q;

  logic                  stall, flush;
  logic [ADDR_WIDTH-1:0] tgt, pc_inc;

  assign stall  = pc_stall_and_flush[STALL_BIT];
  assign flush  = pc_stall_and_flush[FLUSH_BIT];
  // Redirect targets are forced word-aligned.
  assign tgt    = branch_target & ~ADDR_WIDTH'(3);
  assign pc_inc = pc_q + INCR;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      pc_q         <= RST_PC;
      req_adr_q    <= RST_PC;
      hold_instr_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q <= S_BUSY;
          if (flush) begin
            pc_q      <= tgt;
            req_adr_q <= tgt;
          end else begin
            req_adr_q <= pc_q;
          end
        end
        S_BUSY: begin
          if (wb_ack_i) begin
            if (flush) begin
              pc_q      <= tgt;
              req_adr_q <= tgt;
            end else if (!stall) begin
              pc_q      <= pc_inc;
              req_adr_q <= pc_inc;
            end else begin
              hold_instr_q <= wb_dat_i;
              state_q      <= S_HOLD;
            end
          end else if (flush) begin
            // Bus cycle cannot be abandoned; finish it and discard the data.
            pc_q    <= tgt;
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (flush) pc_q <= tgt;
          if (wb_ack_i) begin
            req_adr_q <= flush ? tgt : pc_q;
            state_q   <= S_BUSY;
          end
        end
        S_HOLD: begin
          if (flush) begin
            pc_q      <= tgt;
            req_adr_q <= tgt;
            state_q   <= S_BUSY;
          end else if (!stall) begin
            pc_q      <= pc_inc;
            req_adr_q <= pc_inc;
            state_q   <= S_BUSY;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign wb_cyc_o   = (state_q == S_BUSY) || (state_q == S_DRAIN);
  assign wb_stb_o   = wb_cyc_o;
  assign wb_adr_o   = req_adr_q;
  assign wb_sel_o   = 4'hF;
  assign wb_we_o    = 1'b0;

  assign im_o       = (state_q == S_IDLE) || (state_q == S_DRAIN) ||
                      ((state_q == S_BUSY) && !wb_ack_i);
  assign if_valid_o = (((state_q == S_BUSY) && wb_ack_i) || (state_q == S_HOLD)) &&
                      !stall && !flush;
  assign if_pc_o    = pc_q;
  assign if_instr_o = (state_q == S_HOLD) ? hold_instr_q : wb_dat_i;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed vector table, reset corner cases, and a
// randomized run against a transaction-level model.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  pc_stall_and_flush;
  logic [31:0] branch_target;
  logic        im_o, if_valid_o;
  logic [31:0] if_pc_o, if_instr_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_ack_i;

  int n_cmp = 0;
  int n_err = 0;

  if_fetch dut (
    .clk(clk), .reset(reset), .pc_stall_and_flush(pc_stall_and_flush),
    .branch_target(branch_target), .im_o(im_o), .if_valid_o(if_valid_o),
    .if_pc_o(if_pc_o), .if_instr_o(if_instr_o), .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o), .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st, fl, ack;
    logic [31:0] dat, tgt;
    logic        e_cyc;
    logic [31:0] e_adr;
    logic        e_im, e_vld;
    logic [31:0] e_pc, e_instr;
  } vec_t;

  function automatic vec_t mk(logic st, logic fl, logic ack, logic [31:0] dat,
                              logic [31:0] tgt, logic e_cyc, logic [31:0] e_adr,
                              logic e_im, logic e_vld, logic [31:0] e_pc,
                              logic [31:0] e_instr);
    vec_t v;
    v.st = st; v.fl = fl; v.ack = ack; v.dat = dat; v.tgt = tgt;
    v.e_cyc = e_cyc; v.e_adr = e_adr; v.e_im = e_im; v.e_vld = e_vld;
    v.e_pc = e_pc; v.e_instr = e_instr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic e_cyc, input logic [31:0] e_adr,
                            input logic e_im, input logic e_vld, input logic [31:0] e_pc,
                            input logic [31:0] e_instr);
    chk({tag, ".cyc"}, {31'd0, wb_cyc_o}, {31'd0, e_cyc});
    chk({tag, ".stb"}, {31'd0, wb_stb_o}, {31'd0, e_cyc});
    chk({tag, ".im"},  {31'd0, im_o},     {31'd0, e_im});
    chk({tag, ".vld"}, {31'd0, if_valid_o}, {31'd0, e_vld});
    chk({tag, ".pc"},  if_pc_o, e_pc);
    if (e_cyc) chk({tag, ".adr"}, wb_adr_o, e_adr);
    if (e_vld) chk({tag, ".instr"}, if_instr_o, e_instr);
  endtask

  // Drive at posedge+1, check at posedge+5, then advance one cycle.
  task automatic apply_vec(input string tag, input vec_t v);
    pc_stall_and_flush = {v.fl, v.st};
    wb_ack_i = v.ack; wb_dat_i = v.dat; branch_target = v.tgt;
    #4;
    check_outs(tag, v.e_cyc, v.e_adr, v.e_im, v.e_vld, v.e_pc, v.e_instr);
    @(posedge clk); #1;
  endtask

  // Transaction-level reference: is a bus request open, is its response
  // stale, is a stalled word parked, and is this the first cycle out of reset.
  logic        m_first, m_bus, m_stale, m_have;
  logic [31:0] m_pc, m_req, m_held;

  task automatic model_reset();
    m_first = 1; m_bus = 0; m_stale = 0; m_have = 0;
    m_pc = 32'h8000_0000; m_req = 32'h8000_0000; m_held = 0;
  endtask

  task automatic model_step(input logic st, input logic fl, input logic ack,
                            input logic [31:0] dat, input logic [31:0] tgt);
    logic [31:0] t;
    t = tgt & 32'hFFFF_FFFC;
    if (m_first) begin
      m_first = 0; m_bus = 1;
      if (fl) m_pc = t;
      m_req = m_pc;
    end else if (m_have) begin
      if (fl) begin m_pc = t; m_req = t; m_have = 0; m_bus = 1; end
      else if (!st) begin m_pc = m_pc + 4; m_req = m_pc; m_have = 0; m_bus = 1; end
    end else if (m_stale) begin
      if (fl) m_pc = t;
      if (ack) begin m_stale = 0; m_req = m_pc; end
    end else if (ack) begin
      if (fl) begin m_pc = t; m_req = t; end
      else if (!st) begin m_pc = m_pc + 4; m_req = m_pc; end
      else begin m_have = 1; m_held = dat; m_bus = 0; end
    end else if (fl) begin
      m_pc = t; m_stale = 1;
    end
  endtask

  vec_t tbl[18];

  initial begin
    reset = 1'b0; pc_stall_and_flush = 2'b00; branch_target = '0;
    wb_dat_i = '0; wb_ack_i = 1'b0;

    // Reset state
    #7;
    check_outs("rst", 1'b0, 32'h8000_0000, 1'b1, 1'b0, 32'h8000_0000, 32'h0);
    chk("rst.sel", {28'd0, wb_sel_o}, 32'hF);
    chk("rst.we", {31'd0, wb_we_o}, 32'd0);
    @(posedge clk); #1; reset = 1'b1;

    //             st fl ack dat           tgt           cyc adr           im vld pc            instr
    tbl[0]  = mk(0, 0, 0, 32'h0,        32'h0,        0, 32'h8000_0000, 1, 0, 32'h8000_0000, 32'h0);
    tbl[1]  = mk(0, 0, 0, 32'h0,        32'h0,        1, 32'h8000_0000, 1, 0, 32'h8000_0000, 32'h0);
    tbl[2]  = mk(0, 0, 1, 32'hA000_0000, 32'h0,       1, 32'h8000_0000, 0, 1, 32'h8000_0000, 32'hA000_0000);
    tbl[3]  = mk(1, 0, 1, 32'hA000_0001, 32'h0,       1, 32'h8000_0004, 0, 0, 32'h8000_0004, 32'h0);
    tbl[4]  = mk(1, 0, 0, 32'h0,        32'h0,        0, 32'h8000_0004, 0, 0, 32'h8000_0004, 32'h0);
    tbl[5]  = mk(1, 0, 1, 32'hDEAD_BEEF, 32'h0,       0, 32'h8000_0004, 0, 0, 32'h8000_0004, 32'h0);
    tbl[6]  = mk(0, 0, 0, 32'h5555_5555, 32'h0,       0, 32'h8000_0004, 0, 1, 32'h8000_0004, 32'hA000_0001);
    tbl[7]  = mk(0, 0, 1, 32'hA000_0002, 32'h0,       1, 32'h8000_0008, 0, 1, 32'h8000_0008, 32'hA000_0002);
    // Flush while waiting on a slow slave
    tbl[8]  = mk(0, 1, 0, 32'h0,        32'h8000_1002, 1, 32'h8000_000C, 1, 0, 32'h8000_000C, 32'h0);
    tbl[9]  = mk(0, 0, 0, 32'h0,        32'h0,        1, 32'h8000_000C, 1, 0, 32'h8000_1000, 32'h0);
    tbl[10] = mk(0, 0, 0, 32'h0,        32'h0,        1, 32'h8000_000C, 1, 0, 32'h8000_1000, 32'h0);
    tbl[11] = mk(0, 0, 1, 32'hBAD0_BAD0, 32'h0,       1, 32'h8000_000C, 1, 0, 32'h8000_1000, 32'h0);
    tbl[12] = mk(0, 0, 1, 32'hB000_0000, 32'h0,       1, 32'h8000_1000, 0, 1, 32'h8000_1000, 32'hB000_0000);
    // Flush and stall together in the ack cycle
    tbl[13] = mk(1, 1, 1, 32'hB000_0001, 32'h8000_2000, 1, 32'h8000_1004, 0, 0, 32'h8000_1004, 32'h0);
    tbl[14] = mk(0, 0, 0, 32'h0,        32'h0,        1, 32'h8000_2000, 1, 0, 32'h8000_2000, 32'h0);
    // PC wrap at the top of the address space
    tbl[15] = mk(0, 1, 1, 32'h0,        32'hFFFF_FFFF, 1, 32'h8000_2000, 0, 0, 32'h8000_2000, 32'h0);
    tbl[16] = mk(0, 0, 1, 32'hC000_0000, 32'h0,       1, 32'hFFFF_FFFC, 0, 1, 32'hFFFF_FFFC, 32'hC000_0000);
    tbl[17] = mk(0, 0, 0, 32'h0,        32'h0,        1, 32'h0000_0000, 1, 0, 32'h0000_0000, 32'h0);

    for (int i = 0; i < 18; i++) apply_vec($sformatf("v%0d", i), tbl[i]);

    // Reset asserted mid-transaction: bus drops without waiting for a clock
    wb_ack_i = 1'b0; pc_stall_and_flush = 2'b00;
    #2 reset = 1'b0;
    #1;
    check_outs("midrst", 1'b0, 32'h8000_0000, 1'b1, 1'b0, 32'h8000_0000, 32'h0);
    chk("midrst.adr", wb_adr_o, 32'h8000_0000);
    wb_ack_i = 1'b1; wb_dat_i = 32'hBAD1_BAD1;
    @(posedge clk); #1; reset = 1'b1;
    // Late ack arriving in IDLE after release is ignored
    apply_vec("late", mk(0, 0, 1, 32'hBAD2_BAD2, 32'h0, 0, 32'h8000_0000, 1, 0, 32'h8000_0000, 32'h0));
    apply_vec("refetch", mk(0, 0, 1, 32'hD000_0000, 32'h0, 1, 32'h8000_0000, 0, 1, 32'h8000_0000, 32'hD000_0000));

    // Randomized run against the model
    reset = 1'b0; wb_ack_i = 1'b0; pc_stall_and_flush = 2'b00;
    @(posedge clk); #1; reset = 1'b1;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      logic st, fl, ack;
      logic [31:0] dat, tgt;
      logic e_vld, e_im;
      st  = ($urandom_range(0, 9) < 3);
      fl  = ($urandom_range(0, 9) == 0);
      ack = $urandom_range(0, 1) == 1;
      dat = $urandom;
      tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
      pc_stall_and_flush = {fl, st};
      wb_ack_i = ack; wb_dat_i = dat; branch_target = tgt;
      e_vld = !st && !fl && ((m_bus && !m_stale && ack) || m_have);
      e_im  = m_first || (m_bus && (m_stale || !ack));
      #4;
      check_outs("rnd", m_bus, m_req, e_im, e_vld, m_pc, m_have ? m_held : dat);
      @(posedge clk);
      model_step(st, fl, ack, dat, tgt);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
